dispatcher_bram_pingpong: RTL and testbench

Parametrised, multi-channel ping-pong successor to the single-buffered dispatcher BRAM. Each of `NUM_CH` channels (channel 0 = left, channel 1 = right in the default configuration) owns two banks. Each bank holds packed exponents, aligned exponents and mantissas. The block unpacks exponents internally with a per-channel FSM, so `dispatcher_control` only streams FETCH lines. The compute engine reads one bank while the next FETCH fills the other.

---
 rtl/dispatcher_bram_pingpong.sv | 187 ++++++++++++++++++
 tb/tb_dispatcher_bram_pingpong.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatcher_bram_pingpong.sv
// Multi-channel ping-pong dispatcher BRAM: each channel fills one bank from FETCH
// lines (unpacking exponents in place) while the consumer reads the other bank.
module dispatcher_bram_pingpong #(
  parameter int DATA_WIDTH       = 256,
  parameter int EXP_WIDTH        = 8,
  parameter int NUM_CH           = 2,
  parameter int EXP_PACKED_DEPTH = 16,
  parameter int MAN_DEPTH        = 512,
  localparam int WR_AW  = $clog2(EXP_PACKED_DEPTH + MAN_DEPTH),
  localparam int MAN_AW = $clog2(MAN_DEPTH),
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic [DATA_WIDTH-1:0]          i_wr_data,
  input  logic [WR_AW-1:0]               i_wr_addr,
  input  logic                           i_wr_en,
  input  logic [CH_W-1:0]                i_wr_ch,
  output logic [NUM_CH-1:0]              o_wr_full,
  output logic [NUM_CH-1:0]              o_overflow,
  output logic [NUM_CH-1:0]              o_unpack_busy,
  input  logic [NUM_CH-1:0]              i_rd_en,
  input  logic [NUM_CH*MAN_AW-1:0]       i_rd_man_addr,
  input  logic [NUM_CH*MAN_AW-1:0]       i_rd_exp_addr,
  output logic [NUM_CH*DATA_WIDTH-1:0]   o_rd_man,
  output logic [NUM_CH*EXP_WIDTH-1:0]    o_rd_exp,
  output logic [NUM_CH-1:0]              o_bank_valid,
  output logic [NUM_CH-1:0]              o_rd_bank,
  input  logic [NUM_CH-1:0]              i_rd_release
);

  localparam int EPL = DATA_WIDTH / EXP_WIDTH;
  localparam int PAW = (EXP_PACKED_DEPTH > 1) ? $clog2(EXP_PACKED_DEPTH) : 1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_UNPACK = 1'b1;

  localparam logic [WR_AW:0]    PK_END   = (WR_AW+1)'(EXP_PACKED_DEPTH);
  localparam logic [WR_AW:0]    WR_END   = (WR_AW+1)'(EXP_PACKED_DEPTH + MAN_DEPTH);
  localparam logic [MAN_AW-1:0] MAN_LAST = MAN_AW'(MAN_DEPTH - 1);
  localparam logic [PAW-1:0]    PK_LAST  = PAW'(EXP_PACKED_DEPTH - 1);

  if (MAN_DEPTH != EXP_PACKED_DEPTH * EPL) begin : g_depth_check
    $error("MAN_DEPTH must equal EXP_PACKED_DEPTH*DATA_WIDTH/EXP_WIDTH");
  end

  // Write address decode is shared; only the channel match differs per channel.
  logic [WR_AW:0]    wr_addr_x;
  logic              wr_is_pk;
  logic              wr_is_man;
  logic [PAW-1:0]    pk_wa;
  logic [MAN_AW-1:0] man_wa;

  assign wr_addr_x = {1'b0, i_wr_addr};
  assign wr_is_pk  = (wr_addr_x < PK_END);
  assign wr_is_man = !wr_is_pk && (wr_addr_x < WR_END);
  assign pk_wa     = PAW'(i_wr_addr);
  assign man_wa    = MAN_AW'(wr_addr_x - PK_END);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] pk_mem  [2][EXP_PACKED_DEPTH];
    logic [DATA_WIDTH-1:0] man_mem [2][MAN_DEPTH];
    logic [EXP_WIDTH-1:0]  aln_mem [2][MAN_DEPTH];

    logic [0:0]            state_q, state_d;
    logic [MAN_AW-1:0]     ucnt_q, ucnt_d;
    logic                  fill_bank_q, fill_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [1:0]            bank_vld_q, bank_vld_d;
    logic                  exp_done_q, exp_done_d;
    logic                  man_done_q, man_done_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] rd_man_q;
    logic [EXP_WIDTH-1:0]  rd_exp_q;

    logic                  wr_hit, wr_drop, pk_acc, man_acc;
    logic                  unpacking, complete, rel_ok;
    logic [PAW-1:0]        line_idx;
    logic [MAN_AW-1:0]     byte_idx;
    logic [DATA_WIDTH-1:0] pk_line;
    logic [EXP_WIDTH-1:0]  unpacked;
    logic [MAN_AW-1:0]     man_ra, exp_ra;

    assign wr_hit    = i_wr_en && (i_wr_ch == CH_W'(c)) && (wr_is_pk || wr_is_man);
    assign unpacking = (state_q == S_UNPACK);
    assign wr_drop   = wr_hit && (bank_vld_q[fill_bank_q] || (wr_is_pk && unpacking));
    assign pk_acc    = wr_hit && !wr_drop && wr_is_pk;
    assign man_acc   = wr_hit && !wr_drop && wr_is_man;
    assign complete  = exp_done_q && man_done_q;
    assign rel_ok    = i_rd_release[c] && bank_vld_q[rd_bank_q];

    assign line_idx  = PAW'(ucnt_q / MAN_AW'(EPL));
    assign byte_idx  = ucnt_q % MAN_AW'(EPL);
    assign pk_line   = pk_mem[fill_bank_q][line_idx];
    assign unpacked  = pk_line[byte_idx*EXP_WIDTH +: EXP_WIDTH];

    assign man_ra    = i_rd_man_addr[c*MAN_AW +: MAN_AW];
    assign exp_ra    = i_rd_exp_addr[c*MAN_AW +: MAN_AW];

    // Completion fills one bank while release frees the other, so both may apply.
    always_comb begin
      state_d     = state_q;
      ucnt_d      = ucnt_q;
      exp_done_d  = exp_done_q;
      man_done_d  = man_done_q;
      fill_bank_d = fill_bank_q;
      rd_bank_d   = rd_bank_q;
      bank_vld_d  = bank_vld_q;
      ovf_d       = ovf_q | wr_drop;
      if (pk_acc && (pk_wa == PK_LAST)) begin
        state_d    = S_UNPACK;
        ucnt_d     = '0;
        exp_done_d = 1'b0;
      end
      if (unpacking) begin
        ucnt_d = ucnt_q + 1'b1;
        if (ucnt_q == MAN_LAST) begin
          state_d    = S_IDLE;
          exp_done_d = 1'b1;
        end
      end
      if (man_acc && (man_wa == MAN_LAST)) begin
        man_done_d = 1'b1;
      end
      if (complete) begin
        bank_vld_d[fill_bank_q] = 1'b1;
        fill_bank_d             = ~fill_bank_q;
        exp_done_d              = 1'b0;
        man_done_d              = 1'b0;
      end
      if (rel_ok) begin
        bank_vld_d[rd_bank_q] = 1'b0;
        rd_bank_d             = ~rd_bank_q;
      end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        state_q     <= S_IDLE;
        ucnt_q      <= '0;
        fill_bank_q <= 1'b0;
        rd_bank_q   <= 1'b0;
        bank_vld_q  <= '0;
        exp_done_q  <= 1'b0;
        man_done_q  <= 1'b0;
        ovf_q       <= 1'b0;
        rd_man_q    <= '0;
        rd_exp_q    <= '0;
      end else begin
        state_q     <= state_d;
        ucnt_q      <= ucnt_d;
        fill_bank_q <= fill_bank_d;
        rd_bank_q   <= rd_bank_d;
        bank_vld_q  <= bank_vld_d;
        exp_done_q  <= exp_done_d;
        man_done_q  <= man_done_d;
        ovf_q       <= ovf_d;
        if (i_rd_en[c]) begin
          rd_man_q <= man_mem[rd_bank_q][man_ra];
          rd_exp_q <= aln_mem[rd_bank_q][exp_ra];
        end
      end
    end

    // Storage is deliberately not reset; validity is tracked by bank_vld_q alone.
    always_ff @(posedge i_clk) begin
      if (pk_acc) begin
        pk_mem[fill_bank_q][pk_wa] <= i_wr_data;
      end
      if (man_acc) begin
        man_mem[fill_bank_q][man_wa] <= i_wr_data;
      end
      if (unpacking) begin
        aln_mem[fill_bank_q][ucnt_q] <= unpacked;
      end
    end

    assign o_wr_full[c]                          = bank_vld_q[fill_bank_q];
    assign o_overflow[c]                         = ovf_q;
    assign o_unpack_busy[c]                      = unpacking;
    assign o_bank_valid[c]                       = bank_vld_q[rd_bank_q];
    assign o_rd_bank[c]                          = rd_bank_q;
    assign o_rd_man[c*DATA_WIDTH +: DATA_WIDTH]  = rd_man_q;
    assign o_rd_exp[c*EXP_WIDTH +: EXP_WIDTH]    = rd_exp_q;
  end

endmodule

// File: tb/tb_dispatcher_bram_pingpong.sv
// Randomized bench for dispatcher_bram_pingpong, checked against an edge-counting
// model of bank occupancy and plain arrays holding what each bank should contain.
module tb_dispatcher_bram_pingpong;

  localparam int DW     = 256;
  localparam int EW     = 8;
  localparam int NC     = 2;
  localparam int PD     = 16;
  localparam int MD     = 512;
  localparam int EPL    = DW / EW;
  localparam int WR_AW  = 10;
  localparam int MAN_AW = 9;
  localparam int CH_W   = 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0]        wr_data;
  logic [WR_AW-1:0]     wr_addr;
  logic                 wr_en;
  logic [CH_W-1:0]      wr_ch;
  logic [NC-1:0]        rd_en;
  logic [NC*MAN_AW-1:0] rd_man_addr;
  logic [NC*MAN_AW-1:0] rd_exp_addr;
  logic [NC-1:0]        rd_release;
  logic [NC-1:0]        o_wr_full, o_overflow, o_unpack_busy, o_bank_valid, o_rd_bank;
  logic [NC*DW-1:0]     o_rd_man;
  logic [NC*EW-1:0]     o_rd_exp;

  dispatcher_bram_pingpong #(
    .DATA_WIDTH(DW), .EXP_WIDTH(EW), .NUM_CH(NC), .EXP_PACKED_DEPTH(PD), .MAN_DEPTH(MD)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_wr_data(wr_data), .i_wr_addr(wr_addr), .i_wr_en(wr_en), .i_wr_ch(wr_ch),
    .o_wr_full(o_wr_full), .o_overflow(o_overflow), .o_unpack_busy(o_unpack_busy),
    .i_rd_en(rd_en), .i_rd_man_addr(rd_man_addr), .i_rd_exp_addr(rd_exp_addr),
    .o_rd_man(o_rd_man), .o_rd_exp(o_rd_exp),
    .o_bank_valid(o_bank_valid), .o_rd_bank(o_rd_bank), .i_rd_release(rd_release)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Bank contents per channel/bank, plus counts of completed (m_c) and released (m_r)
  // FETCHes. Fill bank = m_c%2, read bank = m_r%2, occupancy = m_c-m_r.
  logic [DW-1:0] m_pk  [NC][2][PD];
  logic [DW-1:0] m_man [NC][2][MD];
  int            m_c[NC], m_r[NC], m_t0[NC], m_me[NC];
  bit            m_ovf[NC];
  logic [DW-1:0] last_man[NC];
  logic [EW-1:0] last_exp[NC];
  int            cyc = 0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [EW-1:0] m_exp(input int c, input int b, input int a);
    logic [DW-1:0] line;
    line = m_pk[c][b][a / EPL];
    return line[(a % EPL)*EW +: EW];
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_c[c] = 0; m_r[c] = 0; m_t0[c] = -1; m_me[c] = -1; m_ovf[c] = 1'b0;
      last_man[c] = '0; last_exp[c] = '0;
    end
  endtask

  // A write sampled at edge e: dropped if both banks are occupied, or if it is a
  // packed line while the previous packed set is still being unpacked (t0, t0+MD].
  task automatic model_write(input int c, input int a, input logic [DW-1:0] d, input int e);
    int fb;
    if (a >= PD + MD) return;
    fb = m_c[c] % 2;
    if (m_c[c] - m_r[c] == 2) begin m_ovf[c] = 1'b1; return; end
    if (a < PD && m_t0[c] >= 0 && e > m_t0[c] && e <= m_t0[c] + MD) begin
      m_ovf[c] = 1'b1; return;
    end
    if (a < PD) begin
      m_pk[c][fb][a] = d;
      if (a == PD - 1) m_t0[c] = e;
    end else begin
      m_man[c][fb][a - PD] = d;
      if (a == PD + MD - 1 && m_me[c] < 0) m_me[c] = e;
    end
  endtask

  // One clock edge: update the model for this edge, then wait until just after it.
  task automatic step();
    int e;
    bit comp[NC];
    bit rel[NC];
    e = cyc + 1;
    for (int c = 0; c < NC; c++) begin
      comp[c] = (m_t0[c] >= 0) && (m_me[c] >= 0) && (max2(m_t0[c] + MD, m_me[c]) + 1 == e);
      rel[c]  = rd_release[c] && (m_c[c] - m_r[c] > 0);
    end
    if (wr_en) model_write(int'(wr_ch), int'(wr_addr), wr_data, e);
    for (int c = 0; c < NC; c++) begin
      if (comp[c]) begin m_c[c]++; m_t0[c] = -1; m_me[c] = -1; end
      if (rel[c]) m_r[c]++;
    end
    @(posedge clk);
    #1;
    cyc = e;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wr(input int c, input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_ch = CH_W'(c); wr_addr = WR_AW'(a); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic fetch_range(input int c, input int lo, input int hi, input bit special);
    logic [DW-1:0] d;
    for (int a = lo; a <= hi; a++) begin
      d = rand_line();
      if (special && a == 0) begin d[7:0] = 8'h7F; d[15:8] = 8'h80; end
      if (special && a == PD) d = {(DW/8){8'hA5}};
      wr(c, a, d);
    end
  endtask

  task automatic release_ch(input int c);
    rd_release[c] = 1'b1;
    step();
    rd_release = '0;
  endtask

  task automatic rd_both(input logic [NC-1:0] en, input int ma0, input int ea0,
                         input int ma1, input int ea1);
    int ma, ea, b;
    rd_en = en;
    rd_man_addr = {MAN_AW'(ma1), MAN_AW'(ma0)};
    rd_exp_addr = {MAN_AW'(ea1), MAN_AW'(ea0)};
    step();
    rd_en = '0;
    for (int c = 0; c < NC; c++) begin
      if (en[c]) begin
        ma = (c == 0) ? ma0 : ma1;
        ea = (c == 0) ? ea0 : ea1;
        b  = m_r[c] % 2;
        last_man[c] = m_man[c][b][ma];
        last_exp[c] = m_exp(c, b, ea);
        check($sformatf("rd_man ch%0d a%0d", c, ma), o_rd_man[c*DW +: DW], last_man[c]);
        check($sformatf("rd_exp ch%0d a%0d", c, ea), DW'(o_rd_exp[c*EW +: EW]), DW'(last_exp[c]));
      end
    end
  endtask

  task automatic rd(input int c, input int ma, input int ea);
    rd_both((c == 0) ? 2'b01 : 2'b10, ma, ea, ma, ea);
  endtask

  task automatic rd_random(input int c, input int n);
    for (int i = 0; i < n; i++) rd(c, $urandom_range(0, MD-1), $urandom_range(0, MD-1));
  endtask

  task automatic check_status(input string tag);
    for (int c = 0; c < NC; c++) begin
      check($sformatf("%s valid%0d", tag, c), DW'(o_bank_valid[c]), DW'(m_c[c] - m_r[c] > 0));
      check($sformatf("%s full%0d", tag, c), DW'(o_wr_full[c]), DW'(m_c[c] - m_r[c] == 2));
      check($sformatf("%s rd_bank%0d", tag, c), DW'(o_rd_bank[c]), DW'(m_r[c] % 2));
      check($sformatf("%s ovf%0d", tag, c), DW'(o_overflow[c]), DW'(m_ovf[c]));
      check($sformatf("%s busy%0d", tag, c), DW'(o_unpack_busy[c]),
            DW'(m_t0[c] >= 0 && cyc >= m_t0[c] && cyc < m_t0[c] + MD));
    end
  endtask

  // Asserts reset asynchronously just after an edge and checks every output is cleared.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst rd_man", o_rd_man[DW-1:0], '0);
    check("rst rd_man1", o_rd_man[2*DW-1:DW], '0);
    check("rst rd_exp", DW'(o_rd_exp), '0);
    check("rst flags", DW'({o_wr_full, o_overflow, o_unpack_busy, o_bank_valid, o_rd_bank}), '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- tests ----------------
  initial begin
    wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_man_addr = '0; rd_exp_addr = '0; rd_release = '0;
    model_reset();

    // 1: single FETCH with fixed exponent/mantissa markers
    do_reset();
    check_status("t1 reset");
    fetch_range(0, 0, PD + MD - 1, 1'b1);
    check_status("t1 pre");
    step();
    check_status("t1 done");
    rd(0, 0, 0);
    check("t1 exp0 const", DW'(o_rd_exp[EW-1:0]), DW'(8'h7F));
    check("t1 man0 const", o_rd_man[DW-1:0], {(DW/8){8'hA5}});
    rd(0, 1, 1);
    check("t1 exp1 const", DW'(o_rd_exp[EW-1:0]), DW'(8'h80));
    rd_man_addr = '0; rd_exp_addr = '0;
    step();
    check("t1 hold man", o_rd_man[DW-1:0], last_man[0]);
    check("t1 hold exp", DW'(o_rd_exp[EW-1:0]), DW'(last_exp[0]));
    rd_random(0, 4);

    // 2: second FETCH fills the other bank; a third write is dropped
    fetch_range(0, 0, PD + MD - 1, 1'b0);
    step();
    check_status("t2 full");
    wr(0, PD + 5, rand_line());
    check_status("t2 ovf");
    release_ch(0);
    check_status("t2 rel");
    rd_random(0, 4);

    // 3: release lands on the same edge as the next completion
    do_reset();
    fetch_range(0, 0, PD + MD - 1, 1'b0);
    step();
    fetch_range(0, 0, PD + MD - 1, 1'b0);
    rd_release[0] = 1'b1;
    step();
    rd_release = '0;
    check_status("t3 both");
    rd_random(0, 4);

    // 4: packed rewrite while unpacking is refused and does not disturb exponents
    fetch_range(0, 0, PD - 1, 1'b0);
    repeat (10) step();
    check_status("t4 busy");
    wr(0, 3, rand_line());
    check_status("t4 drop");
    fetch_range(0, PD, PD + MD - 1, 1'b0);
    step();
    check_status("t4 done");
    release_ch(0);
    check_status("t4 rel");
    for (int i = 0; i < 6; i++) rd(0, $urandom_range(0, MD-1), 3*EPL + $urandom_range(0, EPL-1));

    // 5: reset part-way through unpacking, then a clean FETCH into bank 0
    do_reset();
    fetch_range(0, 0, PD - 1, 1'b0);
    repeat (200) step();
    check_status("t5 mid");
    do_reset();
    check_status("t5 reset");
    fetch_range(0, 0, PD + MD - 1, 1'b0);
    step();
    check_status("t5 fresh");
    rd_random(0, 4);

    // 6: interleaved channels
    do_reset();
    for (int a = 0; a < PD + MD; a++) begin
      wr(0, a, rand_line());
      wr(1, a, rand_line());
    end
    step();
    step();
    check_status("t6 done");
    for (int i = 0; i < 8; i++) begin
      rd_both(2'b11, $urandom_range(0, MD-1), $urandom_range(0, MD-1),
              $urandom_range(0, MD-1), $urandom_range(0, MD-1));
    end
    rd_both(2'b11, 7, 40, 7, 40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
